ppu: RTL and testbench

PPU -- requirements
Module: ppu

---
 rtl/ppu.sv | 155 +++++++++++++++
 tb/tb_ppu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu.sv
// rtl/ppu.sv - post-processing unit: scale, bias, max-magnitude, reciprocal, int8 quantize
// Five-state pipeline-free FSM; outputs change only on the edge leaving QUANT.
module ppu (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [383:0] partial_sum,
    input  logic [7:0]   scale,
    input  logic [7:0]   bias,
    input  logic         valid,
    output logic [17:0]  vec_max_wire,
    output logic [17:0]  reciprocal_wire,
    output logic [135:0] output_data,
    output logic         done_wire
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCALE = 3'd1,
        MAX   = 3'd2,
        RECIP = 3'd3,
        QUANT = 3'd4
    } state_t;

    localparam logic signed [31:0] SAT24_HI = 32'sd8388607;
    localparam logic signed [31:0] SAT24_LO = -32'sd8388608;
    localparam logic [24:0]        RECIP_NUM = 25'd16646144;   // 127 * 2^17
    localparam logic [24:0]        RECIP_MAX = 25'h003FFFF;

    state_t         state;
    logic [383:0]   x_r;
    logic [7:0]     scale_r;
    logic [7:0]     bias_r;
    logic [383:0]   y_r;
    logic [17:0]    vm_r;
    logic [17:0]    r_r;

    logic signed [31:0] prod [16];
    logic signed [31:0] sum  [16];
    logic [383:0]       y_next;

    always_comb begin
        y_next = '0;
        for (int i = 0; i < 16; i++) begin
            prod[i] = $signed({{8{x_r[24*i+23]}}, x_r[24*i +: 24]}) * $signed({24'b0, scale_r});
            sum[i]  = (prod[i] >>> 4) + $signed({{24{bias_r[7]}}, bias_r});
            if (sum[i] > SAT24_HI)
                y_next[24*i +: 24] = 24'h7FFFFF;
            else if (sum[i] < SAT24_LO)
                y_next[24*i +: 24] = 24'h800000;
            else
                y_next[24*i +: 24] = sum[i][23:0];
        end
    end

    logic [23:0] mag [16];
    logic [23:0] m_max;
    logic [17:0] vm_next;

    // The most negative value has no positive twin in 24 bits; clamp it.
    always_comb begin
        m_max = '0;
        for (int i = 0; i < 16; i++) begin
            if (y_r[24*i +: 24] == 24'h800000)
                mag[i] = 24'h7FFFFF;
            else if (y_r[24*i+23])
                mag[i] = -y_r[24*i +: 24];
            else
                mag[i] = y_r[24*i +: 24];
            if (mag[i] > m_max)
                m_max = mag[i];
        end
        vm_next = 18'(m_max >> 6);
    end

    logic [24:0] quot;
    logic [17:0] r_next;

    always_comb begin
        quot   = '0;
        r_next = '0;
        if (vm_r != 18'd0) begin
            quot   = RECIP_NUM / {7'b0, vm_r};
            r_next = (quot > RECIP_MAX) ? 18'h3FFFF : quot[17:0];
        end
    end

    logic signed [17:0] t  [16];
    logic signed [35:0] qp [16];
    logic signed [35:0] qs [16];
    logic [127:0]       q_next;

    always_comb begin
        q_next = '0;
        for (int i = 0; i < 16; i++) begin
            t[i]  = $signed(y_r[24*i+6 +: 18]);
            qp[i] = $signed({{18{t[i][17]}}, t[i]}) * $signed({18'b0, r_r}) + 36'sd65536;
            qs[i] = qp[i] >>> 17;
            if (qs[i] > 36'sd127)
                q_next[8*i +: 8] = 8'h7F;
            else if (qs[i] < -36'sd128)
                q_next[8*i +: 8] = 8'h80;
            else
                q_next[8*i +: 8] = qs[i][7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state           <= IDLE;
            x_r             <= '0;
            scale_r         <= '0;
            bias_r          <= '0;
            y_r             <= '0;
            vm_r            <= '0;
            r_r             <= '0;
            vec_max_wire    <= '0;
            reciprocal_wire <= '0;
            output_data     <= '0;
            done_wire       <= 1'b0;
        end else begin
            done_wire <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        x_r     <= partial_sum;
                        scale_r <= scale;
                        bias_r  <= bias;
                        state   <= SCALE;
                    end
                end
                SCALE: begin
                    y_r   <= y_next;
                    state <= MAX;
                end
                MAX: begin
                    vm_r  <= vm_next;
                    state <= RECIP;
                end
                RECIP: begin
                    r_r   <= r_next;
                    state <= QUANT;
                end
                QUANT: begin
                    vec_max_wire    <= vm_r;
                    reciprocal_wire <= r_r;
                    output_data     <= {vm_r[16:9], q_next};
                    done_wire       <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu.sv
// tb/tb_ppu.sv - self-checking bench for ppu: directed table, random vs model, control corners
module tb_ppu;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [383:0] partial_sum = '0;
    logic [7:0]   scale = '0;
    logic [7:0]   bias = '0;
    logic         valid = 1'b0;
    logic [17:0]  vec_max_wire;
    logic [17:0]  reciprocal_wire;
    logic [135:0] output_data;
    logic         done_wire;

    int n_checks = 0;
    int n_err = 0;

    ppu dut (
        .clk(clk),
        .rst_n(rst_n),
        .partial_sum(partial_sum),
        .scale(scale),
        .bias(bias),
        .valid(valid),
        .vec_max_wire(vec_max_wire),
        .reciprocal_wire(reciprocal_wire),
        .output_data(output_data),
        .done_wire(done_wire)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [383:0] ps;
        logic [7:0]   sc;
        logic [7:0]   bi;
        logic [17:0]  vm;
        logic [17:0]  r;
        logic [135:0] od;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: whole-number arithmetic straight from the scaling/quantizing rules.
    function automatic void model(input logic [383:0] ps, input logic [7:0] sc, input logic [7:0] bi,
                                  output logic [17:0] vm, output logic [17:0] r, output logic [135:0] od);
        longint y [16];
        longint m, a, x, rr, tq, q;
        m = 0;
        for (int i = 0; i < 16; i++) begin
            x = longint'($signed(ps[24*i +: 24]));
            y[i] = ((x * longint'(sc)) >>> 4) + longint'($signed(bi));
            if (y[i] > 8388607) y[i] = 8388607;
            if (y[i] < -8388608) y[i] = -8388608;
            a = (y[i] < 0) ? -y[i] : y[i];
            if (a > 8388607) a = 8388607;
            if (a > m) m = a;
        end
        vm = 18'(m / 64);
        if (vm == 0) rr = 0;
        else begin
            rr = 16646144 / longint'(vm);
            if (rr > 262143) rr = 262143;
        end
        r = 18'(rr);
        od = '0;
        for (int i = 0; i < 16; i++) begin
            tq = y[i] >>> 6;
            q = (tq * rr + 65536) >>> 17;
            if (q > 127) q = 127;
            if (q < -128) q = -128;
            od[8*i +: 8] = 8'(q);
        end
        od[135:128] = vm[16:9];
    endfunction

    task automatic do_vec(input logic [383:0] ps, input logic [7:0] sc, input logic [7:0] bi,
                          output int lat);
        @(negedge clk);
        partial_sum = ps;
        scale = sc;
        bias = bi;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (done_wire) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_idle_cycles(input string name, input int n);
        int seen;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1 if (done_wire) seen++;
        end
        chk(name, 136'(seen), 136'd0);
    endtask

    function automatic logic [383:0] fill(input logic [23:0] v);
        logic [383:0] p;
        for (int i = 0; i < 16; i++) p[24*i +: 24] = v;
        return p;
    endfunction

    initial begin
        logic [383:0] ps;
        logic [135:0] od;
        logic [17:0]  evm, er;
        logic [135:0] eod;
        logic [7:0]   sc, bi;
        int lat, nd, seen;
        int dt [8];

        // Directed table
        ps = fill(24'h400000);
        ps[24*15 +: 24] = 24'h600000;
        ps[24*6 +: 24]  = 24'h7C0000;
        ps[24*0 +: 24]  = 24'h700000;
        od = {8'hF8, {16{8'h42}}};
        od[8*6 +: 8]  = 8'h7F;
        od[8*15 +: 8] = 8'h62;
        od[8*0 +: 8]  = 8'h73;
        tbl[0] = '{ps, 8'd16, 8'd1, 18'h1F000, 18'd131, od};
        tbl[1] = '{384'd0, 8'd16, 8'd0, 18'h0, 18'd0, 136'd0};
        ps = fill(24'h400000);
        ps[23:0] = 24'h840000;
        od = {8'hF8, {16{8'h42}}};
        od[7:0] = 8'h81;
        tbl[2] = '{ps, 8'd16, 8'd0, 18'h1F000, 18'd131, od};
        // floor(127 * 2^17 / 0x1FFFF) = 127
        tbl[3] = '{fill(24'h500000), 8'd32, 8'd0, 18'h1FFFF, 18'd127, {8'hFF, {16{8'h7F}}}};

        // Reset
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_vec_max", 136'(vec_max_wire), 136'd0);
        chk("reset_recip", 136'(reciprocal_wire), 136'd0);
        chk("reset_data", output_data, 136'd0);
        chk("reset_done", 136'(done_wire), 136'd0);
        @(negedge clk) rst_n = 1'b0;

        for (int v = 0; v < 4; v++) begin
            do_vec(tbl[v].ps, tbl[v].sc, tbl[v].bi, lat);
            chk($sformatf("tbl%0d_latency", v), 136'(lat), 136'd4);
            chk($sformatf("tbl%0d_vec_max", v), 136'(vec_max_wire), 136'(tbl[v].vm));
            chk($sformatf("tbl%0d_recip", v), 136'(reciprocal_wire), 136'(tbl[v].r));
            chk($sformatf("tbl%0d_data", v), output_data, tbl[v].od);
            @(posedge clk);
            #1 chk($sformatf("tbl%0d_done_width", v), 136'(done_wire), 136'd0);
            chk($sformatf("tbl%0d_hold", v), output_data, tbl[v].od);
        end

        // Random vectors against the model
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 16; i++)
                ps[24*i +: 24] = 24'($signed(24'($urandom)) >>> $urandom_range(0, 22));
            sc = 8'($urandom_range(0, 255));
            bi = 8'($urandom);
            model(ps, sc, bi, evm, er, eod);
            do_vec(ps, sc, bi, lat);
            chk($sformatf("rnd%0d_latency", n), 136'(lat), 136'd4);
            chk($sformatf("rnd%0d_vec_max", n), 136'(vec_max_wire), 136'(evm));
            chk($sformatf("rnd%0d_recip", n), 136'(reciprocal_wire), 136'(er));
            chk($sformatf("rnd%0d_data", n), output_data, eod);
        end

        // valid and inputs wiggled while busy must be ignored
        model(tbl[0].ps, tbl[0].sc, tbl[0].bi, evm, er, eod);
        @(negedge clk);
        partial_sum = tbl[0].ps; scale = tbl[0].sc; bias = tbl[0].bi; valid = 1'b1;
        @(posedge clk);
        nd = 0; lat = -1;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                @(posedge clk);
            end
            #1;
            if (k > 0 && done_wire) begin
                nd++;
                if (lat < 0) lat = k;
            end
            valid = (k < 3) ? ((k % 2) == 0) : 1'b0;
            for (int i = 0; i < 12; i++) partial_sum[32*i +: 32] = $urandom;
            scale = 8'($urandom);
            bias = 8'($urandom);
        end
        chk("busy_done_count", 136'(nd), 136'd1);
        chk("busy_latency", 136'(lat), 136'd4);
        chk("busy_data", output_data, eod);
        chk("busy_vec_max", 136'(vec_max_wire), 136'(evm));

        // valid held high: back-to-back results
        ps = tbl[2].ps;
        model(ps, 8'd16, 8'd0, evm, er, eod);
        @(negedge clk);
        partial_sum = ps; scale = 8'd16; bias = 8'd0; valid = 1'b1;
        nd = 0;
        for (int c = 1; c <= 21; c++) begin
            @(posedge clk);
            #1 if (done_wire) begin
                if (nd < 8) dt[nd] = c;
                nd++;
                chk($sformatf("b2b_data%0d", nd), output_data, eod);
            end
        end
        chk("b2b_count", 136'(nd), 136'd4);
        if (nd >= 3) begin
            chk("b2b_first", 136'(dt[0]), 136'd5);
            chk("b2b_gap1", 136'(dt[1] - dt[0]), 136'd5);
            chk("b2b_gap2", 136'(dt[2] - dt[1]), 136'd5);
        end
        @(negedge clk) valid = 1'b0;
        repeat (8) @(posedge clk);

        // Reset while in RECIP aborts the vector
        @(negedge clk);
        partial_sum = tbl[0].ps; scale = 8'd16; bias = 8'd1; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        chk("abort_vec_max", 136'(vec_max_wire), 136'd0);
        chk("abort_recip", 136'(reciprocal_wire), 136'd0);
        chk("abort_data", output_data, 136'd0);
        check_idle_cycles("abort_no_done", 10);

        // Reset wins over valid on the same edge
        @(negedge clk);
        rst_n = 1'b1; valid = 1'b1;
        @(posedge clk);
        #1 begin rst_n = 1'b0; valid = 1'b0; end
        check_idle_cycles("rst_priority_no_done", 10);

        // Block still works after the aborts
        do_vec(tbl[3].ps, tbl[3].sc, tbl[3].bi, lat);
        chk("post_reset_latency", 136'(lat), 136'd4);
        chk("post_reset_data", output_data, tbl[3].od);
        seen = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
